// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control sequencer: one FSM spreads each instruction over 3-5 states
// and stalls memory states on the MIO_ready handshake.
module multicycle_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] OP,
    input  logic [5:0] Funct,
    input  logic       Zero,
    input  logic       MIO_ready,
    output logic       PCWrite,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       CPU_MIO,
    output logic       IRWrite,
    output logic [1:0] RegDst,
    output logic [1:0] MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       ExtOp,
    output logic [2:0] ALU_Control,
    output logic [1:0] PCSource,
    output logic [3:0] state,
    output logic       illegal
);

    typedef enum logic [3:0] {
        ST_IF   = 4'd0,  ST_ID  = 4'd1,  ST_MADR = 4'd2,  ST_MRD = 4'd3,
        ST_LWB  = 4'd4,  ST_MWR = 4'd5,  ST_REX  = 4'd6,  ST_RWB = 4'd7,
        ST_BR   = 4'd8,  ST_J   = 4'd9,  ST_IEX  = 4'd10, ST_IWB = 4'd11,
        ST_JAL  = 4'd12, ST_JR  = 4'd13
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'b010, ALU_SUB = 3'b110, ALU_AND = 3'b000,
                           ALU_OR  = 3'b001, ALU_SLT = 3'b111, ALU_NOR = 3'b100,
                           ALU_XOR = 3'b011;

    localparam logic [5:0] OP_RTYPE = 6'b000000, OP_LW   = 6'b100011, OP_SW   = 6'b101011,
                           OP_BEQ   = 6'b000100, OP_BNE  = 6'b000101, OP_J    = 6'b000010,
                           OP_JAL   = 6'b000011, OP_ADDI = 6'b001000, OP_ANDI = 6'b001100,
                           OP_ORI   = 6'b001101, OP_SLTI = 6'b001010;
    localparam logic [5:0] FUNCT_JR = 6'b001000;

    state_t cur_state, nxt_state;
    logic [2:0] r_alu;
    logic [2:0] i_alu;
    logic       i_ext;

    // NOTE: sequential state uses non-blocking assignment; the async reset is in the sensitivity list.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cur_state <= ST_IF;
        else        cur_state <= nxt_state;
    end

    assign state = cur_state;

    // R-type and I-type ALU decodes; IR is stable for the whole instruction.
    always_comb begin
        unique case (Funct)
            6'b100010: r_alu = ALU_SUB;
            6'b100100: r_alu = ALU_AND;
            6'b100101: r_alu = ALU_OR;
            6'b101010: r_alu = ALU_SLT;
            6'b100111: r_alu = ALU_NOR;
            6'b100110: r_alu = ALU_XOR;
            default:   r_alu = ALU_ADD;
        endcase
    end

    always_comb begin
        i_alu = ALU_ADD;
        i_ext = 1'b1;
        case (OP)
            OP_SLTI: i_alu = ALU_SLT;
            OP_ANDI: begin i_alu = ALU_AND; i_ext = 1'b0; end
            OP_ORI:  begin i_alu = ALU_OR;  i_ext = 1'b0; end
            default: ;
        endcase
    end

    // NOTE: every output gets a default before the case so no latch can be inferred.
    always_comb begin
        nxt_state   = ST_IF;
        PCWrite     = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        CPU_MIO     = 1'b0;
        IRWrite     = 1'b0;
        RegDst      = 2'b00;
        MemtoReg    = 2'b00;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ExtOp       = 1'b0;
        ALU_Control = 3'b000;
        PCSource    = 2'b00;
        illegal     = 1'b0;

        case (cur_state)
            ST_IF: begin
                MemRead     = 1'b1;
                CPU_MIO     = 1'b1;
                ALUSrcB     = 2'b01;
                ALU_Control = ALU_ADD;
                // Held in reset, the fetch decode shows but nothing is loaded.
                PCWrite     = MIO_ready & reset;
                IRWrite     = MIO_ready & reset;
                nxt_state   = MIO_ready ? ST_ID : ST_IF;
            end
            ST_ID: begin
                ALUSrcB     = 2'b11;
                ExtOp       = 1'b1;
                ALU_Control = ALU_ADD;
                case (OP)
                    OP_RTYPE:                         nxt_state = (Funct == FUNCT_JR) ? ST_JR : ST_REX;
                    OP_LW, OP_SW:                     nxt_state = ST_MADR;
                    OP_BEQ, OP_BNE:                   nxt_state = ST_BR;
                    OP_J:                             nxt_state = ST_J;
                    OP_JAL:                           nxt_state = ST_JAL;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: nxt_state = ST_IEX;
                    default: begin
                        nxt_state = ST_IF;
                        illegal   = 1'b1;
                    end
                endcase
            end
            ST_MADR: begin
                ALUSrcA     = 1'b1;
                ALUSrcB     = 2'b10;
                ExtOp       = 1'b1;
                ALU_Control = ALU_ADD;
                nxt_state   = (OP == OP_SW) ? ST_MWR : ST_MRD;
            end
            ST_MRD: begin
                IorD      = 1'b1;
                MemRead   = 1'b1;
                CPU_MIO   = 1'b1;
                nxt_state = MIO_ready ? ST_LWB : ST_MRD;
            end
            ST_LWB: begin
                MemtoReg = 2'b01;
                RegWrite = 1'b1;
            end
            ST_MWR: begin
                IorD      = 1'b1;
                MemWrite  = 1'b1;
                CPU_MIO   = 1'b1;
                nxt_state = MIO_ready ? ST_IF : ST_MWR;
            end
            ST_REX: begin
                ALUSrcA     = 1'b1;
                ALU_Control = r_alu;
                nxt_state   = ST_RWB;
            end
            ST_RWB: begin
                RegDst   = 2'b01;
                RegWrite = 1'b1;
            end
            ST_BR: begin
                ALUSrcA     = 1'b1;
                ALU_Control = ALU_SUB;
                PCSource    = 2'b01;
                PCWrite     = (OP == OP_BNE) ? ~Zero : Zero;
            end
            ST_J: begin
                PCSource = 2'b10;
                PCWrite  = 1'b1;
            end
            ST_JAL: begin
                PCSource = 2'b10;
                PCWrite  = 1'b1;
                RegDst   = 2'b10;
                MemtoReg = 2'b10;
                RegWrite = 1'b1;
            end
            ST_JR: begin
                PCSource = 2'b11;
                PCWrite  = 1'b1;
            end
            ST_IEX: begin
                ALUSrcA     = 1'b1;
                ALUSrcB     = 2'b10;
                ALU_Control = i_alu;
                ExtOp       = i_ext;
                nxt_state   = ST_IWB;
            end
            ST_IWB: begin
                ALU_Control = i_alu;
                ExtOp       = i_ext;
                RegWrite    = 1'b1;
            end
            default: nxt_state = ST_IF;
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Table-driven bench for multicycle_ctrl: per-cycle expected output vectors plus
// hand-written reset-in-MRD sequence.
module tb_multicycle_ctrl;

    logic       clk;
    logic       reset;
    logic [5:0] OP;
    logic [5:0] Funct;
    logic       Zero;
    logic       MIO_ready;
    logic       PCWrite, IorD, MemRead, MemWrite, CPU_MIO, IRWrite;
    logic [1:0] RegDst, MemtoReg;
    logic       RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB;
    logic       ExtOp;
    logic [2:0] ALU_Control;
    logic [1:0] PCSource;
    logic [3:0] state;
    logic       illegal;

    int checks = 0;
    int errors = 0;

    multicycle_ctrl dut (
        .clk(clk), .reset(reset), .OP(OP), .Funct(Funct), .Zero(Zero), .MIO_ready(MIO_ready),
        .PCWrite(PCWrite), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
        .CPU_MIO(CPU_MIO), .IRWrite(IRWrite), .RegDst(RegDst), .MemtoReg(MemtoReg),
        .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ExtOp(ExtOp),
        .ALU_Control(ALU_Control), .PCSource(PCSource), .state(state), .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {PCWrite,IorD,MemRead,MemWrite,CPU_MIO,IRWrite,RegDst,MemtoReg,RegWrite,
    //  ALUSrcA,ALUSrcB,ExtOp,ALU_Control,PCSource,state,illegal}
    logic [24:0] outs;
    assign outs = {PCWrite, IorD, MemRead, MemWrite, CPU_MIO, IRWrite, RegDst, MemtoReg,
                   RegWrite, ALUSrcA, ALUSrcB, ExtOp, ALU_Control, PCSource, state, illegal};

    function automatic logic [24:0] ex(input logic pcw, iord, mr, mw, mio, irw,
                                       input logic [1:0] rd, mtr, input logic rw, asa,
                                       input logic [1:0] asb, input logic ext,
                                       input logic [2:0] alu, input logic [1:0] pcs,
                                       input logic [3:0] st, input logic ill);
        return {pcw, iord, mr, mw, mio, irw, rd, mtr, rw, asa, asb, ext, alu, pcs, st, ill};
    endfunction

    function automatic logic [24:0] e_if(input logic rdy);
        return ex(rdy, 0, 1, 0, 1, rdy, 2'b00, 2'b00, 0, 0, 2'b01, 0, 3'b010, 2'b00, 4'd0, 0);
    endfunction

    function automatic logic [24:0] e_id(input logic ill);
        return ex(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 2'b11, 1, 3'b010, 2'b00, 4'd1, ill);
    endfunction

    typedef struct {
        logic [5:0]  op;
        logic [5:0]  funct;
        logic        zero;
        logic        rdy;
        logic [24:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [5:0] op, funct, input logic zero, rdy, input logic [24:0] exp);
        vec_t v;
        v.op = op; v.funct = funct; v.zero = zero; v.rdy = rdy; v.exp = exp;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000, BEQ = 6'b000100,
                           BNE = 6'b000101, JAL = 6'b000011, ORI = 6'b001101, BAD = 6'b111111;

    initial begin
        // lw with a one-cycle fetch wait first
        add(LW, 0, 0, 0, e_if(0));
        add(LW, 0, 0, 1, e_if(1));
        add(LW, 0, 0, 1, e_id(0));
        add(LW, 0, 0, 1, ex(0,0,0,0,0,0,2'b00,2'b00,0,1,2'b10,1,3'b010,2'b00,4'd2,0));
        add(LW, 0, 0, 1, ex(0,1,1,0,1,0,2'b00,2'b00,0,0,2'b00,0,3'b000,2'b00,4'd3,0));
        add(LW, 0, 0, 1, ex(0,0,0,0,0,0,2'b00,2'b01,1,0,2'b00,0,3'b000,2'b00,4'd4,0));
        // R-type add then sub
        add(RT, 6'b100000, 0, 1, e_if(1));
        add(RT, 6'b100000, 0, 1, e_id(0));
        add(RT, 6'b100000, 0, 1, ex(0,0,0,0,0,0,2'b00,2'b00,0,1,2'b00,0,3'b010,2'b00,4'd6,0));
        add(RT, 6'b100000, 0, 1, ex(0,0,0,0,0,0,2'b01,2'b00,1,0,2'b00,0,3'b000,2'b00,4'd7,0));
        add(RT, 6'b100010, 0, 1, e_if(1));
        add(RT, 6'b100010, 0, 1, e_id(0));
        add(RT, 6'b100010, 0, 1, ex(0,0,0,0,0,0,2'b00,2'b00,0,1,2'b00,0,3'b110,2'b00,4'd6,0));
        add(RT, 6'b100010, 0, 1, ex(0,0,0,0,0,0,2'b01,2'b00,1,0,2'b00,0,3'b000,2'b00,4'd7,0));
        // beq Zero=1, beq Zero=0, bne Zero=0
        add(BEQ, 0, 1, 1, e_if(1));
        add(BEQ, 0, 1, 1, e_id(0));
        add(BEQ, 0, 1, 1, ex(1,0,0,0,0,0,2'b00,2'b00,0,1,2'b00,0,3'b110,2'b01,4'd8,0));
        add(BEQ, 0, 0, 1, e_if(1));
        add(BEQ, 0, 0, 1, e_id(0));
        add(BEQ, 0, 0, 1, ex(0,0,0,0,0,0,2'b00,2'b00,0,1,2'b00,0,3'b110,2'b01,4'd8,0));
        add(BNE, 0, 0, 1, e_if(1));
        add(BNE, 0, 0, 1, e_id(0));
        add(BNE, 0, 0, 1, ex(1,0,0,0,0,0,2'b00,2'b00,0,1,2'b00,0,3'b110,2'b01,4'd8,0));
        // sw with three wait cycles in MWR: 7 cycles total
        add(SW, 0, 0, 1, e_if(1));
        add(SW, 0, 0, 1, e_id(0));
        add(SW, 0, 0, 1, ex(0,0,0,0,0,0,2'b00,2'b00,0,1,2'b10,1,3'b010,2'b00,4'd2,0));
        for (int i = 0; i < 4; i++)
            add(SW, 0, 0, (i == 3), ex(0,1,0,1,1,0,2'b00,2'b00,0,0,2'b00,0,3'b000,2'b00,4'd5,0));
        // jal then ori
        add(JAL, 0, 0, 1, e_if(1));
        add(JAL, 0, 0, 1, e_id(0));
        add(JAL, 0, 0, 1, ex(1,0,0,0,0,0,2'b10,2'b10,1,0,2'b00,0,3'b000,2'b10,4'd12,0));
        add(ORI, 0, 0, 1, e_if(1));
        add(ORI, 0, 0, 1, e_id(0));
        add(ORI, 0, 0, 1, ex(0,0,0,0,0,0,2'b00,2'b00,0,1,2'b10,0,3'b001,2'b00,4'd10,0));
        add(ORI, 0, 0, 1, ex(0,0,0,0,0,0,2'b00,2'b00,1,0,2'b00,0,3'b001,2'b00,4'd11,0));
        // jr
        add(RT, 6'b001000, 0, 1, e_if(1));
        add(RT, 6'b001000, 0, 1, e_id(0));
        add(RT, 6'b001000, 0, 1, ex(1,0,0,0,0,0,2'b00,2'b00,0,0,2'b00,0,3'b000,2'b11,4'd13,0));
        // illegal opcode: pulse in ID, then back to IF
        add(BAD, 0, 0, 1, e_if(1));
        add(BAD, 0, 0, 1, e_id(1));
        add(BAD, 0, 0, 1, e_if(1));

        reset = 1'b0; OP = 0; Funct = 0; Zero = 0; MIO_ready = 1'b1;
        #2;
        check("reset_hold", {7'd0, outs}, {7'd0, e_if(0)});
        #5;
        reset = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            OP = vecs[i].op; Funct = vecs[i].funct; Zero = vecs[i].zero; MIO_ready = vecs[i].rdy;
            #1;
            check($sformatf("vec%0d", i), {7'd0, outs}, {7'd0, vecs[i].exp});
            @(posedge clk); #1;
        end

        // Reset asserted while lw waits in MRD.
        OP = LW; Funct = 0; Zero = 0; MIO_ready = 1'b1;
        begin
            int n = 0;
            while (state != 4'd3 && n < 10) begin
                if (state == 4'd2) MIO_ready = 1'b0;
                @(posedge clk); #1;
                n++;
            end
            check("reach_mrd", {28'd0, state}, 32'd3);
        end
        #1;
        check("mrd_wait", {7'd0, outs}, {7'd0, ex(0,1,1,0,1,0,2'b00,2'b00,0,0,2'b00,0,3'b000,2'b00,4'd3,0)});
        MIO_ready = 1'b1;
        reset = 1'b0;
        #1;
        check("async_reset", {7'd0, outs}, {7'd0, e_if(0)});
        @(posedge clk); #1;
        check("reset_over_edge", {7'd0, outs}, {7'd0, e_if(0)});
        reset = 1'b1;
        #1;
        check("reset_release", {7'd0, outs}, {7'd0, e_if(1)});
        @(posedge clk); #1;
        check("after_release_id", {28'd0, state}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
